// File: rtl/cmn_pkg.sv
// rtl/cmn_pkg.sv - shared register-slice definitions
// Holds the slice-kind enum used by reg_slice_pipe and reg_slice_stage, and the
// occupancy width helper shared by the pipe and its users.
package cmn_pkg;

    typedef enum logic [1:0] {
        RS_BYPASS = 2'd0,
        RS_FWD    = 2'd1,
        RS_BWD    = 2'd2,
        RS_FULL   = 2'd3
    } rs_mode_e;

    // Width of an occupancy count for a chain of `stages` slices. The floor of
    // one bit keeps the port legal when the chain is empty (STAGES=0).
    function automatic int rs_occ_w(int stages);
        return (stages == 0) ? 1 : $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/reg_slice_stage.sv
// rtl/reg_slice_stage.sv - one valid/ready register slice stage
// Purpose: a single slice of kind MODE between an upstream (s_*) and a
// downstream (m_*) valid/ready channel.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   flush          - synchronous clear; blocks both handshakes while high
//   s_vld/s_rdy/s_pld - upstream channel
//   m_vld/m_rdy/m_pld - downstream channel
//   occ            - number of entries held by this stage (0..2)
module reg_slice_stage
    import cmn_pkg::*;
#(
    parameter type      PLD_TYPE = logic,
    parameter rs_mode_e MODE     = RS_FWD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       s_vld,
    output logic       s_rdy,
    input  PLD_TYPE    s_pld,
    output logic       m_vld,
    input  logic       m_rdy,
    output PLD_TYPE    m_pld,
    output logic [1:0] occ
);

    if (MODE == RS_FWD) begin : g_fwd
        logic    vld_r;
        PLD_TYPE pld_r;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_r <= 1'b0;
                pld_r <= '0;
            end else if (flush) begin
                vld_r <= 1'b0;
            end else if (s_vld && s_rdy) begin
                vld_r <= 1'b1;
                pld_r <= s_pld;
            end else if (m_rdy) begin
                vld_r <= 1'b0;
            end
        end

        // Ready may look through to m_rdy so a full slice still streams 1/cycle.
        assign s_rdy = (!vld_r || m_rdy) && !flush;
        assign m_vld = vld_r && !flush;
        assign m_pld = pld_r;
        assign occ   = {1'b0, vld_r};

    end else if (MODE == RS_BWD) begin : g_bwd
        logic    skid_vld;
        PLD_TYPE skid_pld;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                skid_vld <= 1'b0;
                skid_pld <= '0;
            end else if (flush) begin
                skid_vld <= 1'b0;
            end else if (s_vld && s_rdy && !m_rdy) begin
                skid_vld <= 1'b1;
                skid_pld <= s_pld;
            end else if (m_rdy) begin
                skid_vld <= 1'b0;
            end
        end

        // Ready comes straight from a flop; valid/payload pass through when the
        // skid is empty, which is what breaks the backward timing path.
        assign s_rdy = !skid_vld && !flush;
        assign m_vld = (s_vld || skid_vld) && !flush;
        assign m_pld = skid_vld ? skid_pld : s_pld;
        assign occ   = {1'b0, skid_vld};

    end else if (MODE == RS_FULL) begin : g_full
        logic    main_vld;
        logic    skid_vld;
        PLD_TYPE main_pld;
        PLD_TYPE skid_pld;
        logic    acc;
        logic    del;

        assign acc = s_vld && s_rdy;
        assign del = m_vld && m_rdy;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                main_vld <= 1'b0;
                skid_vld <= 1'b0;
                main_pld <= '0;
                skid_pld <= '0;
            end else if (flush) begin
                main_vld <= 1'b0;
                skid_vld <= 1'b0;
            end else if (del) begin
                // Main drains; refill it from skid first (older), else from input.
                if (skid_vld) begin
                    main_pld <= skid_pld;
                    skid_vld <= 1'b0;
                end else if (acc) begin
                    main_pld <= s_pld;
                end else begin
                    main_vld <= 1'b0;
                end
            end else if (acc) begin
                if (main_vld) begin
                    skid_vld <= 1'b1;
                    skid_pld <= s_pld;
                end else begin
                    main_vld <= 1'b1;
                    main_pld <= s_pld;
                end
            end
        end

        assign s_rdy = !skid_vld && !flush;
        assign m_vld = main_vld && !flush;
        assign m_pld = main_pld;
        assign occ   = {1'b0, main_vld} + {1'b0, skid_vld};

    end else begin : g_byp
        assign s_rdy = m_rdy;
        assign m_vld = s_vld;
        assign m_pld = s_pld;
        assign occ   = '0;
    end

endmodule

// File: rtl/reg_slice_pipe.sv
// rtl/reg_slice_pipe.sv - chain of STAGES valid/ready register slices
// Purpose: carries PLD_TYPE payloads in order through STAGES slices of kind
// MODE (STAGES legal range 0..8); STAGES=0 or RS_BYPASS is a plain wire-through.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   flush             - synchronous clear of every held entry
//   s_vld/s_rdy/s_pld - upstream channel
//   m_vld/m_rdy/m_pld - downstream channel
//   occ               - total entries held across all stages
module reg_slice_pipe
    import cmn_pkg::*;
#(
    parameter type      PLD_TYPE = logic,
    parameter int       STAGES   = 1,
    parameter rs_mode_e MODE     = RS_FWD,
    localparam int      OCC_W    = rs_occ_w(STAGES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_vld,
    output logic             s_rdy,
    input  PLD_TYPE          s_pld,
    output logic             m_vld,
    input  logic             m_rdy,
    output PLD_TYPE          m_pld,
    output logic [OCC_W-1:0] occ
);

    if (STAGES == 0 || MODE == RS_BYPASS) begin : g_wire
        assign s_rdy = m_rdy;
        assign m_vld = s_vld;
        assign m_pld = s_pld;
        assign occ   = '0;
    end else begin : g_pipe
        // Each stage keeps its own link signals; neighbours are reached by
        // index so the chain has no shared arrays across combinational paths.
        for (genvar i = 0; i < STAGES; i++) begin : g_st
            logic             up_vld;
            logic             up_rdy;
            PLD_TYPE          up_pld;
            logic             dn_vld;
            logic             dn_rdy;
            PLD_TYPE          dn_pld;
            logic [1:0]       st_occ;
            logic [OCC_W-1:0] occ_acc;

            reg_slice_stage #(
                .PLD_TYPE (PLD_TYPE),
                .MODE     (MODE)
            ) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .flush (flush),
                .s_vld (up_vld),
                .s_rdy (up_rdy),
                .s_pld (up_pld),
                .m_vld (dn_vld),
                .m_rdy (dn_rdy),
                .m_pld (dn_pld),
                .occ   (st_occ)
            );

            if (i == 0) begin : g_head
                assign up_vld  = s_vld;
                assign up_pld  = s_pld;
                assign s_rdy   = up_rdy;
                assign occ_acc = OCC_W'(st_occ);
            end else begin : g_link
                assign up_vld  = g_st[i-1].dn_vld;
                assign up_pld  = g_st[i-1].dn_pld;
                assign occ_acc = g_st[i-1].occ_acc + OCC_W'(st_occ);
            end

            if (i == STAGES - 1) begin : g_tail
                assign dn_rdy = m_rdy;
            end else begin : g_mid
                assign dn_rdy = g_st[i+1].up_rdy;
            end
        end

        assign m_vld = g_st[STAGES-1].dn_vld;
        assign m_pld = g_st[STAGES-1].dn_pld;
        assign occ   = g_st[STAGES-1].occ_acc;
    end

endmodule

// File: doc/reg_slice_pipe.md
REG_SLICE_PIPE -- requirements
Module: reg_slice_pipe

Interface
REQ-001 SHALL have parameter PLD_TYPE, default logic, payload type carried unchanged.
REQ-002 SHALL have parameter STAGES, default 1, number of chained slice stages, legal range 0..8.
REQ-003 SHALL have parameter MODE, default RS_FWD, stage kind: RS_BYPASS, RS_FWD, RS_BWD or RS_FULL.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port flush, input, 1, synchronous clear of all held entries.
REQ-007 SHALL have ports s_vld (input, 1), s_rdy (output, 1) and s_pld (input, PLD_TYPE), the upstream valid/ready/payload.
REQ-008 SHALL have ports m_vld (output, 1), m_rdy (input, 1) and m_pld (output, PLD_TYPE), the downstream valid/ready/payload.
REQ-009 SHALL have port occ, output, OCC_W = $clog2(2*STAGES+1), count of valid entries held across all stages.

Function
REQ-010 SHALL complete a transfer on either side only in a cycle where vld && rdy at that side.
REQ-011 SHALL deliver payloads in acceptance order, with none dropped or duplicated except by flush.
REQ-012 SHALL behave as follows when MODE=RS_BYPASS or STAGES=0: wire-through, m_vld=s_vld, m_pld=s_pld, s_rdy=m_rdy, occ=0, and flush has no effect.
REQ-013 SHALL implement each RS_FWD stage as follows: one entry; rdy_in = !vld_r || rdy_out; load on vld_in&&rdy_in; clear vld_r on rdy_out otherwise; latency 1 cycle; throughput 1 per cycle.
REQ-014 SHALL implement each RS_BWD stage as follows: one skid entry; rdy_in = !skid_vld, registered; vld_out = vld_in || skid_vld; pld_out = skid_vld ? skid_pld : pld_in; capture into skid when vld_in && rdy_in && !rdy_out; clear skid on rdy_out; latency 0 cycles.
REQ-015 SHALL implement each RS_FULL stage as follows: main plus skid entries; rdy_in = !skid_vld, registered; vld_out = main_vld; latency 1 cycle; capacity 2; sustains 1 transfer per cycle with both vld and rdy paths registered.
REQ-016 SHALL, when both main and skid are valid and rdy_out=1, move skid to main in the same cycle.
REQ-017 SHALL accept a new input into the freed slot in the same cycle as an output transfer, with no bubble.
REQ-018 SHALL have end-to-end latency of STAGES cycles for RS_FWD and RS_FULL, and 0 cycles for RS_BWD.
REQ-019 SHALL have total capacity of STAGES for RS_FWD and RS_BWD, and 2*STAGES for RS_FULL.
REQ-020 SHALL update occ each cycle as occ + accepted - delivered - (entries cleared by flush), never exceeding capacity.
REQ-021 SHALL, while flush=1, force s_rdy=0 and m_vld=0 combinationally.
REQ-022 SHALL, on the cycle after flush=1, have every valid bit cleared and occ=0.
REQ-023 SHALL give flush priority over any simultaneous load or shift.
REQ-024 SHALL leave m_pld unspecified when m_vld=0.
REQ-025 SHALL NOT be required to hold m_pld stable while m_vld=1 && m_rdy=0, except where upstream payload is combinationally passed through in RS_BWD with an empty skid.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, clear all valid bits and zero all payload registers.
REQ-027 SHALL present outputs m_vld=0 and occ=0 after that reset edge.
REQ-028 SHALL present s_rdy=1 after that reset edge, except s_rdy=m_rdy for bypass.
REQ-029 SHALL discard in-flight entries on reset asserted mid-transfer, with no partial transfer.

Structure
REQ-030 SHALL place the enum rs_mode_e (RS_BYPASS, RS_FWD, RS_BWD, RS_FULL) in shared package cmn_pkg.
REQ-031 SHALL implement one stage as sub-module reg_slice_stage (parameters PLD_TYPE and MODE, ports as the top-level ports minus occ, plus a per-stage occupancy output).
REQ-032 SHALL chain STAGES instances of reg_slice_stage in a generate loop, with occ the sum of per-stage occupancies.

Verification
REQ-033 SHALL cover: RS_FWD, STAGES=2, m_rdy=1, payloads 0x11,0x22,0x33 on consecutive cycles -> outputs on cycles +2,+3,+4, in order, with s_rdy held at 1.
REQ-034 SHALL cover: RS_FULL, STAGES=1, m_rdy=0, s_vld held high with 0xA0.. -> two accepts, then s_rdy=0 and occ=2; release m_rdy -> 0xA0 then 0xA1, with back-to-back accepts resuming.
REQ-035 SHALL cover: RS_BWD, STAGES=1, skid empty, s_vld=1, s_pld=0x5 -> m_vld=1, m_pld=0x5 in the same cycle.
REQ-036 SHALL cover: RS_BWD, m_rdy dropped while sending 0x6 -> 0x6 is held in the skid and s_rdy=0 the next cycle.
REQ-037 SHALL cover: RS_FULL, STAGES=3, occ=4, flush=1 for one cycle with s_vld=1 -> the input is not accepted, m_vld=0 during the flush, and occ=0 with no outputs afterwards.
REQ-038 SHALL cover: rst_n=0 pulse with occ=3 -> occ=0 and m_vld=0 after the edge, and payload 0x7 sent next is delivered alone.
REQ-039 SHALL cover: random s_vld/m_rdy for 10k cycles in every MODE with STAGES in {0,1,4} -> scoreboard order-exact, occ matches the model, and no transfer while flush=1.
